alu_result_monitor: RTL and testbench

//  Receive-side companion to the time-multiplexed ALU. The ALU rotates
//  SUM->SUB->AND->OR->SHL->SHR, changing operation once per TICK_CYCLES.

---
 rtl/alu_result_monitor.sv | 182 ++++++++++++++++++
 tb/tb_alu_result_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_monitor.sv
// ============================================================================
//  Module      : alu_result_monitor
//  Description : Rebuilds the time-multiplexed ALU slot timing and checks the
//                ALU result at the end of each slot. Each check produces one
//                {op, result, match} record that is queued in a
//                first-word-fall-through FIFO and drained over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_monitor #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [7:0] r_in,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic [2:0] rec_op,
    output logic [7:0] rec_result,
    output logic       rec_match,
    output logic       overflow,
    output logic [7:0] err_count
);

    localparam int              CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              FILL_W   = PTR_W + 1;
    localparam int              REC_W    = 12;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_op;
    logic [2:0]        w_op_next;
    logic              w_slot_end;
    logic [7:0]        w_expected;
    logic              w_match;
    logic [REC_W-1:0]  w_rec;

    logic [REC_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic              r_overflow;
    logic [7:0]        r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic [REC_W-1:0]  w_head;

    // ------------------------------------------------------------------
    // Slot timing: counter and op sequencer leave reset on the same edge
    // as the ALU, so both stay cycle-aligned without any handshake.
    // ------------------------------------------------------------------
    assign w_slot_end = (r_count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_slot_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= OP_SUM;
        end else begin
            r_op <= w_op_next;
        end
    end

    always_comb begin
        w_op_next = r_op;
        if (w_slot_end) begin
            case (r_op)
                OP_SUM:  w_op_next = OP_SUB;
                OP_SUB:  w_op_next = OP_AND;
                OP_AND:  w_op_next = OP_OR;
                OP_OR:   w_op_next = OP_SHL;
                OP_SHL:  w_op_next = OP_SHR;
                OP_SHR:  w_op_next = OP_SUM;
                default: w_op_next = OP_SUM;
            endcase
        end
    end

    always_comb begin
        w_expected = 8'h00;
        case (r_op)
            OP_SUM:  w_expected = a_in + b_in;
            OP_SUB:  w_expected = a_in - b_in;
            OP_AND:  w_expected = a_in & b_in;
            OP_OR:   w_expected = a_in | b_in;
            OP_SHL:  w_expected = {a_in[6:0], 1'b0};
            OP_SHR:  w_expected = {1'b0, a_in[7:1]};
            default: w_expected = 8'h00;
        endcase
    end

    assign w_match = (r_in == w_expected);
    assign w_rec   = {r_op, r_in, w_match};

    // ------------------------------------------------------------------
    // Record FIFO. A pop on the same edge as a push into a full FIFO frees
    // the slot, so only a push with no pop on a full FIFO is dropped.
    // ------------------------------------------------------------------
    assign w_empty  = (r_fill == '0);
    assign w_full   = (r_fill == FILL_FULL);
    assign w_pop    = !w_empty && rec_ready;
    assign w_accept = w_slot_end && (!w_full || w_pop);
    assign w_drop   = w_slot_end && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Error count follows every sample, whether or not the record was queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_err      <= 8'h00;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_slot_end && !w_match && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    // Head fields are forced to zero while empty so stale RAM never shows.
    assign w_head     = r_mem[r_rd_ptr];
    assign rec_valid  = !w_empty;
    assign rec_op     = w_empty ? 3'd0 : w_head[11:9];
    assign rec_result = w_empty ? 8'h00 : w_head[8:1];
    assign rec_match  = w_empty ? 1'b0 : w_head[0];
    assign overflow   = r_overflow;
    assign err_count  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_monitor.sv
// ============================================================================
//  Module      : tb_alu_result_monitor
//  Description : Directed bench for alu_result_monitor with a queue-based
//                reference model compared against the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_monitor;

    localparam int TICK  = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic [7:0] r_in = 8'h00;
    logic       rec_ready = 1'b0;
    logic       rec_valid;
    logic [2:0] rec_op;
    logic [7:0] rec_result;
    logic       rec_match;
    logic       overflow;
    logic [7:0] err_count;

    alu_result_monitor #(
        .TICK_CYCLES (TICK),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .r_in       (r_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_op     (rec_op),
        .rec_result (rec_result),
        .rec_match  (rec_match),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int res;
        int match;
        int k;
    } rec_t;

    rec_t q[$];
    rec_t popped[$];
    int   k      = 0;
    int   m_ovf  = 0;
    int   m_err  = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic int expect_val(int op, int a, int b);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            3:       return a | b;
            4:       return (a * 2) % 256;
            5:       return a / 2;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle k since reset release, slot = k / TICK.
    always @(posedge clk or negedge rst_n) begin
        rec_t r;
        int   op;
        int   pop;
        int   push;
        int   was_full;
        if (!rst_n) begin
            q.delete();
            popped.delete();
            k     = 0;
            m_ovf = 0;
            m_err = 0;
        end else begin
            pop      = (q.size() > 0 && rec_ready) ? 1 : 0;
            push     = ((k % TICK) == TICK - 1) ? 1 : 0;
            was_full = (q.size() == DEPTH) ? 1 : 0;
            op       = (k / TICK) % 6;
            r.op     = op;
            r.res    = int'(r_in);
            r.match  = (int'(r_in) == expect_val(op, int'(a_in), int'(b_in))) ? 1 : 0;
            r.k      = k;
            if (push != 0 && r.match == 0 && m_err < 255) m_err++;
            if (pop != 0) begin
                rec_t h;
                h   = q.pop_front();
                h.k = k;
                popped.push_back(h);
            end
            if (push != 0) begin
                if (was_full != 0 && pop == 0) m_ovf = 1;
                else q.push_back(r);
            end
            k++;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("rec_valid", int'(rec_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) begin
            chk("rec_op", int'(rec_op), q[0].op);
            chk("rec_result", int'(rec_result), q[0].res);
            chk("rec_match", int'(rec_match), q[0].match);
        end
        chk("overflow", int'(overflow), m_ovf);
        chk("err_count", int'(err_count), m_err);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(rec_valid), 0);
        chk("rst_op", int'(rec_op), 0);
        chk("rst_result", int'(rec_result), 0);
        chk("rst_match", int'(rec_match), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err", int'(err_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic slot(input logic [7:0] r);
        r_in = r;
        repeat (TICK) @(negedge clk);
    endtask

    int t1_res[6] = '{'h10, 'h0E, 'h01, 'h0F, 'h1E, 'h07};

    initial begin
        // Pin the model's arithmetic on the wrap cases
        chk("model_add_wrap", expect_val(0, 255, 2), 'h01);
        chk("model_sub_wrap", expect_val(1, 255, 2), 'hFD);

        // 1: correct ALU results, all six ops
        do_reset();
        a_in = 8'h0F; b_in = 8'h01; rec_ready = 1'b1;
        for (int i = 0; i < 6; i++) slot(t1_res[i][7:0]);
        repeat (2) @(negedge clk);
        chk("t1_count", popped.size(), 6);
        for (int i = 0; i < 6 && i < popped.size(); i++) begin
            chk("t1_op", popped[i].op, i);
            chk("t1_res", popped[i].res, t1_res[i]);
            chk("t1_match", popped[i].match, 1);
        end
        chk("t1_err", int'(err_count), 0);

        // 2: wrap-around arithmetic, one good and one bad result
        do_reset();
        a_in = 8'hFF; b_in = 8'h02; rec_ready = 1'b1;
        slot(8'h01);
        slot(8'h00);
        repeat (2) @(negedge clk);
        chk("t2_count", popped.size(), 2);
        if (popped.size() >= 2) begin
            chk("t2_match0", popped[0].match, 1);
            chk("t2_res1", popped[1].res, 0);
            chk("t2_match1", popped[1].match, 0);
        end
        chk("t2_err", int'(err_count), 1);

        // 3: no consumer for five slots, then drain
        do_reset();
        a_in = 8'h0F; b_in = 8'h01; rec_ready = 1'b0;
        repeat (5) slot(8'h00);
        chk("t3_held", q.size(), 4);
        chk("t3_overflow", int'(overflow), 1);
        rec_ready = 1'b1;
        repeat (5) @(negedge clk);
        rec_ready = 1'b0;
        chk("t3_drained", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("t3_order", popped[i].op, i);

        // 4: full FIFO, pop coincides with the sample edge
        do_reset();
        a_in = 8'h0F; b_in = 8'h01; rec_ready = 1'b0;
        repeat (4) slot(8'h00);
        r_in = 8'h00;
        repeat (TICK - 1) @(negedge clk);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        chk("t4_overflow", int'(overflow), 0);
        chk("t4_fill", q.size(), 4);
        chk("t4_popped", popped.size(), 1);
        if (q.size() == 4) begin
            chk("t4_head", q[0].op, 1);
            chk("t4_tail", q[3].op, 4);
        end
        slot(8'h00);
        chk("t4_overflow_later", int'(overflow), 1);

        // 5: persistent mismatch saturates the error counter
        do_reset();
        a_in = 8'h00; b_in = 8'h00; rec_ready = 1'b1;
        repeat (300) slot(8'hAA);
        chk("t5_err_sat", int'(err_count), 255);

        // 6: reset mid-slot with records queued
        do_reset();
        a_in = 8'h0F; b_in = 8'h01; rec_ready = 1'b0;
        repeat (3) slot(8'h00);
        repeat (4) @(negedge clk);
        chk("t6_pre_queued", q.size(), 3);
        do_reset();
        rec_ready = 1'b1;
        slot(8'h10);
        repeat (2) @(negedge clk);
        chk("t6_count", popped.size(), 1);
        if (popped.size() >= 1) begin
            chk("t6_op", popped[0].op, 0);
            chk("t6_res", popped[0].res, 'h10);
            chk("t6_match", popped[0].match, 1);
            chk("t6_pop_cycle", popped[0].k, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
